// File: rtl/gcd_controller.sv
// gcd_controller: FSM driving a subtractive GCD datapath with handshake and watchdog; GCD_ITER_COUNT_EN exposes the counter.
module gcd_controller #(
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic gt,
  input  logic lt,
  input  logic eq,
  output logic ldA,
  output logic ldB,
  output logic sel1,
  output logic sel2,
  output logic sel_in,
  output logic busy,
  output logic done,
  output logic err
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [ITER_W-1:0] iter_count
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CMP, DONE, ERR} state_t;
  localparam logic [ITER_W-1:0] CNT_MAX = ITER_W'(MAX_ITER);
  state_t state, state_nx;
  logic [ITER_W-1:0] cnt, cnt_nx;
  logic legal, at_max;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  // exactly one flag set: odd parity rules out 0 and 2, the AND rules out 3
  assign legal  = (gt ^ lt ^ eq) & ~(gt & lt & eq);
  assign at_max = cnt == CNT_MAX;
  assign busy   = state == LOAD_A || state == LOAD_B || state == CMP;
  assign done   = state == DONE;
  assign err    = state == ERR;
`ifdef GCD_ITER_COUNT_EN
  assign iter_count = cnt;
`endif
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ldA      = 1'b0;
    ldB      = 1'b0;
    sel1     = 1'b0;
    sel2     = 1'b0;
    sel_in   = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        state_nx = start ? LOAD_A : state == DONE ? IDLE : state;
        cnt_nx   = start ? '0 : cnt;
      end
      LOAD_A: begin
        sel_in   = 1'b1;
        ldA      = 1'b1;
        state_nx = LOAD_B;
      end
      LOAD_B: begin
        sel_in   = 1'b1;
        ldB      = 1'b1;
        state_nx = CMP;
      end
      CMP: begin
        state_nx = !legal ? ERR : eq ? DONE : at_max ? ERR : CMP;
        if (legal && !eq && !at_max) begin
          ldA    = gt;
          ldB    = lt;
          sel1   = lt;
          sel2   = gt;
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller: datapath model plus scoreboard checking gcd_controller against an arithmetic GCD reference.
module tb_gcd_controller;
  localparam int ITER_W = 16;
  localparam int MAX_IT = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic gt, lt, eq, ldA, ldB, sel1, sel2, sel_in, busy, done, err;
  logic fen = 1'b0, fgt = 1'b0, flt = 1'b0, feq = 1'b0;
  logic [15:0] ra = '0, rb = '0, data_in = '0, sub_v;
  int subs = 0, cyc = 0, compared = 0, mism = 0;
  bit done_prev = 0, err_prev = 0;
`ifdef GCD_ITER_COUNT_EN
  logic [ITER_W-1:0] iter_count;
`endif
  typedef struct {bit is_err; int res; int n; int e0;} exp_t;
  exp_t q[$];

  gcd_controller #(.ITER_W(ITER_W), .MAX_ITER(MAX_IT)) dut (
    .clk(clk), .rst(rst), .start(start), .gt(gt), .lt(lt), .eq(eq),
    .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
    .busy(busy), .done(done), .err(err)
`ifdef GCD_ITER_COUNT_EN
    , .iter_count(iter_count)
`endif
  );

  always #5 clk = ~clk;

  assign sub_v = (sel1 ? rb : ra) - (sel2 ? rb : ra);
  assign gt = fen ? fgt : ra > rb;
  assign lt = fen ? flt : ra < rb;
  assign eq = fen ? feq : ra == rb;

  always @(posedge clk) begin
    if (ldA) ra <= sel_in ? data_in : sub_v;
    if (ldB) rb <= sel_in ? data_in : sub_v;
    if (ldA && sel_in) subs <= 0;
    else if ((ldA || ldB) && !sel_in) subs <= subs + 1;
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    compared++;
    if (act != exp_v) begin
      mism++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // GCD by Euclid's division; the subtractive step count is the sum of quotients minus one
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int x, y, r, s;
    e = '{0, 0, 0, 0};
    if (a == 0 && b == 0) return e;
    if (a == 0 || b == 0) begin
      e.is_err = 1;
      e.n = MAX_IT;
      return e;
    end
    x = a > b ? a : b;
    y = a > b ? b : a;
    s = 0;
    while (y != 0) begin
      s += x / y;
      r = x % y;
      x = y;
      y = r;
    end
    e.res = x;
    e.n = s - 1;
    if (e.n > MAX_IT) begin
      e.is_err = 1;
      e.n = MAX_IT;
    end
    return e;
  endfunction

  // mode 0: no expectation, 1: reference model, 2: immediate error in first CMP
  task automatic kick(input int a, input int b, input int mode);
    exp_t e;
    e = mode == 2 ? exp_t'{1, 0, 0, 0} : model(a, b);
    @(negedge clk);
    start = 1'b1;
    e.e0 = cyc + 1;
    if (mode != 0) q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    data_in = 16'(a);
    @(negedge clk);
    data_in = 16'(b);
  endtask

  task automatic wait_end();
    bit got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = done | err;
    end
    if (!got) chk("run_timeout", 0, 1);
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, int'({ldA, ldB, sel1, sel2, sel_in, busy, done, err}), 0);
`ifdef GCD_ITER_COUNT_EN
    chk({nm, "_cnt"}, int'(iter_count), 0);
`endif
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst && done) begin
        chk("done_single_pulse", int'(done_prev), 0);
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("done_kind", 0, int'(e.is_err));
          chk("result_a", int'(ra), e.res);
          chk("result_b", int'(rb), e.res);
          chk("done_subs", subs, e.n);
          chk("done_latency", cyc - e.e0, 3 + e.n);
`ifdef GCD_ITER_COUNT_EN
          chk("done_iter_count", int'(iter_count), e.n);
`endif
        end
      end
      if (!rst && err && !err_prev) begin
        if (q.size() == 0) chk("unexpected_err", 1, 0);
        else begin
          e = q.pop_front();
          chk("err_kind", 1, int'(e.is_err));
          chk("err_subs", subs, e.n);
          chk("err_latency", cyc - e.e0, 3 + e.n);
`ifdef GCD_ITER_COUNT_EN
          chk("err_iter_count", int'(iter_count), e.n);
`endif
        end
      end
      done_prev = done;
      err_prev = err;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a, b;
    bit got;
    repeat (2) @(negedge clk);
    chk_idle("reset_outputs");
    rst = 1'b0;
    kick(12, 8, 1);
    wait_end();
    kick(7, 7, 1);
    wait_end();
    kick(0, 0, 1);
    wait_end();
    kick(0, 5, 1);
    wait_end();
    repeat (3) @(negedge clk);
    chk("err_held", int'(err), 1);
    chk("no_done_in_err", int'(done), 0);
    kick(12, 8, 1);
    chk("err_cleared", int'(err), 0);
    chk("busy_after_start", int'(busy), 1);
    wait_end();
    fen = 1'b1; fgt = 1'b1; flt = 1'b1;
    kick(5, 3, 2);
    wait_end();
    fgt = 1'b0; flt = 1'b0;
    kick(5, 3, 2);
    wait_end();
    fen = 1'b0;
    kick(65535, 1, 0);
    repeat (4) @(negedge clk);
    chk("busy_before_reset", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("midrun_reset");
    rst = 1'b0;
    kick(12, 8, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end();
    @(negedge clk);
    start = 1'b1;
    q.push_back('{0, 4, 2, cyc + 1});
    @(negedge clk);
    data_in = 16'd12;
    @(negedge clk);
    data_in = 16'd8;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    chk("b2b_first_done", int'(got), 1);
    q.push_back('{0, 3, 2, cyc + 1});
    @(negedge clk);
    start = 1'b0;
    data_in = 16'd9;
    @(negedge clk);
    data_in = 16'd6;
    wait_end();
    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(0, 40);
      b = $urandom_range(0, 40);
      if (i % 7 == 3) a = 0;
      kick(a, b, 1);
      wait_end();
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
